// File: rtl/seq_gen_pkg.sv
// Shared types and default sizing for the serial sequence generator and its detector partners.
package seq_gen_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam int unsigned PAT_W_DEF   = 4;
  localparam int unsigned REP_W_DEF   = 4;
  localparam int unsigned GAP_CYC_DEF = 2;

endpackage

// File: rtl/seq_gen_cnt.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module seq_gen_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_generator_io.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, a given number of times,
// with optional idle gaps between repetitions and a done pulse at the end.
module sequence_generator_io
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W   = PAT_W_DEF,
  parameter int unsigned REP_W   = REP_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAT_W-1:0] in_pattern,
  input  logic [REP_W-1:0] in_reps,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IdxW = $clog2(PAT_W);
  localparam int unsigned GapW = (GAP_CYC == 0) ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(PAT_W - 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic             accept;
  logic             o_d, o_valid_d, done_d;

  logic             idx_load, idx_dec, idx_zero;
  logic [IdxW-1:0]  idx_cnt, idx_next;
  logic             rep_load, rep_dec, rep_zero;
  logic [REP_W-1:0] rep_cnt;
  logic             gap_load, gap_dec, gap_zero;
  logic [GapW-1:0]  gap_cnt;
  logic             unused_zero;

  assign accept      = in_valid && in_ready;
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign unused_zero = rep_zero ^ gap_zero;

  seq_gen_cnt #(.W(IdxW)) u_bit_idx (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (idx_load),
    .load_val (IdxMsb),
    .dec      (idx_dec),
    .count    (idx_cnt),
    .zero     (idx_zero)
  );

  seq_gen_cnt #(.W(REP_W)) u_rep_left (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (rep_load),
    .load_val (in_reps),
    .dec      (rep_dec),
    .count    (rep_cnt),
    .zero     (rep_zero)
  );

  seq_gen_cnt #(.W(GapW)) u_gap_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (GapW'(GAP_CYC)),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .zero     (gap_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      o         <= 1'b0;
      o_valid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      o       <= o_d;
      o_valid <= o_valid_d;
      done    <= done_d;
      if (accept) begin
        pattern_q <= in_pattern;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_load = 1'b0;
    idx_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_reps != '0) begin
            state_d  = SHIFT;
            idx_load = 1'b1;
            rep_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        if (!idx_zero) begin
          idx_dec = 1'b1;
        end else begin
          // Last bit of a repetition is on the wire this cycle.
          rep_dec = 1'b1;
          if (rep_cnt == REP_W'(1)) begin
            state_d = DONE;
          end else if (GAP_CYC == 0) begin
            idx_load = 1'b1;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GapW'(1)) begin
          state_d  = SHIFT;
          idx_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    o_d       = 1'b0;
    o_valid_d = 1'b0;
    done_d    = 1'b0;
    idx_next  = idx_load ? IdxMsb : (idx_cnt - IdxW'(1));
    case (state_d)
      SHIFT: begin
        o_valid_d = 1'b1;
        o_d       = (state_q == IDLE) ? in_pattern[PAT_W-1] : pattern_q[idx_next];
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequence_generator_io.sv
// Randomized and directed bench for sequence_generator_io with a cycle-stamped scoreboard.
module tb_sequence_generator_io;

  localparam int unsigned PW = 4;
  localparam int unsigned RW = 4;
  localparam int unsigned G  = 2;

  logic clock = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, o, o_valid, busy, done;
  logic [PW-1:0] in_pattern;
  logic [RW-1:0] in_reps;

  logic v0, rdy0, o0, ov0, busy0, done0;
  logic [PW-1:0] p0;
  logic [RW-1:0] r0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int det_cnt = 0;
  int nbits = 0;
  logic [3:0] hist;

  typedef struct {
    logic vld;
    logic dn;
    logic b;
    int   cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  sequence_generator_io #(.PAT_W(PW), .REP_W(RW), .GAP_CYC(G)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .in_reps    (in_reps),
    .o          (o),
    .o_valid    (o_valid),
    .busy       (busy),
    .done       (done)
  );

  sequence_generator_io #(.PAT_W(PW), .REP_W(RW), .GAP_CYC(0)) dut0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (v0),
    .in_ready   (rdy0),
    .in_pattern (p0),
    .in_reps    (r0),
    .o          (o0),
    .o_valid    (ov0),
    .busy       (busy0),
    .done       (done0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: every bit and the done pulse, stamped with the cycle it must appear in.
  function automatic void model(input logic [PW-1:0] pat, input int reps, input int acc);
    exp_t e;
    for (int r = 0; r < reps; r++) begin
      for (int j = 0; j < int'(PW); j++) begin
        e.vld = 1'b1;
        e.dn  = 1'b0;
        e.b   = pat[int'(PW) - 1 - j];
        e.cyc = acc + r * int'(PW + G) + j;
        sb.push_back(e);
      end
    end
    e.vld = 1'b0;
    e.dn  = 1'b1;
    e.b   = 1'b0;
    e.cyc = (reps == 0) ? acc : acc + reps * int'(PW) + (reps - 1) * int'(G);
    sb.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (o_valid || done) begin
        if (sb.size() == 0) begin
          check("unexpected output", {o_valid, done, o}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("output value", {o_valid, done, o}, {mon_e.vld, mon_e.dn, mon_e.b});
          check("output cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("o low when idle", o, 0);
      end
    end
  end

  // Loopback 1101 detector (overlapping, valid bits only).
  always @(negedge clock) begin
    if (!reset_n) begin
      hist = '0;
    end else if (o_valid) begin
      hist = {hist[2:0], o};
      nbits++;
      if (hist == 4'b1101) det_cnt++;
    end
  end

  // Called on a negedge; returns on the negedge after the accept edge with in_valid still high.
  task automatic send(input logic [PW-1:0] pat, input logic [RW-1:0] reps,
                      output int acc, output int waited);
    int n = 0;
    in_valid   = 1'b1;
    in_pattern = pat;
    in_reps    = reps;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    waited = n;
    acc    = cyc + 1;
    if (!in_ready) begin
      check("accept timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      model(pat, int'(reps), acc);
      @(negedge clock);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int acc, acc2, w, w2, base, bits0;
    logic [PW-1:0] pat;
    logic [RW-1:0] rr;
    logic [2:0] exp3;

    reset_n = 1'b0;
    in_valid = 1'b0; in_pattern = '0; in_reps = '0;
    v0 = 1'b0; p0 = '0; r0 = '0;
    #1;
    check("reset o", o, 0);
    check("reset o_valid", o_valid, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Single repetition: bits in 4 cycles after accept, done in 5th, ready in 6th.
    send(4'b1101, 4'd1, acc, w);
    in_valid = 1'b0;
    wait_cyc(acc + 4);
    check("t1 ready low at done", in_ready, 0);
    @(negedge clock);
    check("t1 ready after done", in_ready, 1);

    // Three repetitions with gaps; loopback sees three full patterns.
    base = det_cnt;
    send(4'b1101, 4'd3, acc, w);
    in_valid = 1'b0;
    drain();
    check("t2 detector count", det_cnt - base, 3);

    // Zero repetitions: done only, busy for one cycle.
    send(4'b1010, 4'd0, acc, w);
    in_valid = 1'b0;
    check("t4 busy", busy, 1);
    @(negedge clock);
    check("t4 busy cleared", busy, 0);

    // Request held while busy: accepted on the edge right after in_ready returns.
    send(4'b1101, 4'd1, acc, w);
    send(4'b0110, 4'd1, acc2, w2);
    in_valid = 1'b0;
    check("t5 hold cycles", w2, PW + 1);
    check("t5 restart edge", acc2, acc + int'(PW) + 2);
    drain();

    // Back-to-back instance: 1011 x2 gives 8 contiguous bits then done.
    pat = 4'b1011;
    v0 = 1'b1; p0 = pat; r0 = 4'd2;
    check("gap0 ready", rdy0, 1);
    @(negedge clock);
    v0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) exp3 = {1'b1, 1'b0, pat[3 - (k % 4)]};
      else if (k == 8) exp3 = 3'b010;
      else exp3 = 3'b000;
      check("gap0 stream", {ov0, done0, o0}, exp3);
      @(negedge clock);
    end
    check("gap0 idle", busy0, 0);

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      w = $urandom_range(0, 2);
      if (w != 0) begin
        in_valid = 1'b0;
        repeat (w) @(negedge clock);
      end
      pat = PW'($urandom);
      rr  = ($urandom_range(0, 7) == 0) ? RW'(15) : RW'($urandom_range(0, 4));
      send(pat, rr, acc, w2);
    end
    in_valid = 1'b0;
    drain();

    // Settle detector history, then abort a transfer mid-SHIFT with an async reset.
    send(4'b1101, 4'd1, acc, w);
    in_valid = 1'b0;
    drain();
    base  = det_cnt;
    bits0 = nbits;
    send(4'b1101, 4'd3, acc, w);
    in_valid = 1'b0;
    wait_cyc(acc + int'(PW + G) + 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 o", o, 0);
    check("t6 o_valid", o_valid, 0);
    check("t6 busy", busy, 0);
    check("t6 in_ready", in_ready, 1);
    sb.delete();
    #9;
    reset_n = 1'b1;
    repeat (12) @(negedge clock);
    check("t6 bits before abort", nbits - bits0, 6);
    check("t6 detector count", det_cnt - base, 1);
    check("t6 stays idle", busy, 0);

    // Transfer after abort works normally.
    send(4'b1001, 4'd2, acc, w);
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
